seq_match_logger: RTL and testbench

//  Downstream consumer of the serial pattern detector's match flag.
//  - Counts matches and timestamps each one with the bit index at which it completed.
//  - Buffers timestamps in a small FIFO, drained over a valid/ready handshake by the host/CPU side.
//  - Reports saturating match and drop statistics.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/sync_fifo.sv | 57 +++++
 rtl/seq_match_logger.sv | 103 ++++++++++
 tb/tb_seq_match_logger.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector and its match logger.
// Holds default widths/depth and the detector's state encodings.
package seq_det_pkg;

    localparam int unsigned IDX_W_DEF = 16;
    localparam int unsigned CNT_W_DEF = 16;
    localparam int unsigned DEPTH_DEF = 8;

    // Detector FSM encodings, kept here so both blocks agree on them.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StState1 = 2'd1,
        StState2 = 2'd2,
        StState3 = 2'd3
    } det_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Pointer-based synchronous FIFO, DEPTH x WIDTH, no combinational bypass.
// Ports:
//   clk, reset       clock and synchronous active-high reset
//   push, wdata      write request and data (accepted if not full, or full with pop)
//   pop              read request (ignored when empty)
//   rdata            head entry
//   full, empty      status flags
//   level            entries currently held
module sync_fifo
    import seq_det_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEF,
    parameter int unsigned WIDTH = IDX_W_DEF,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    // Extra MSB on each pointer distinguishes full from empty.
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop & ~empty;
    // A pop frees the head slot this cycle, so a push into a full FIFO is allowed.
    assign do_push = push & (~full | do_pop);
    assign level   = wr_ptr_q - rd_ptr_q;
    assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (AW + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/seq_match_logger.sv
// Match logger for the serial pattern detector: timestamps each match with the
// bit index at which it completed, buffers stamps in a FIFO drained by a
// valid/ready consumer, and keeps saturating match/drop statistics.
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   en                bit-valid qualifier; bit index advances when high
//   det_in            detector match flag (counted only with en)
//   clear_stats       clears match_count, drop_count, overflow
//   m_valid, m_ready  FIFO head handshake
//   m_index           oldest unread stamp
//   fifo_level        entries held
//   match_count       saturating count of matches
//   drop_count        saturating count of matches lost to a full FIFO
//   overflow          sticky drop flag
module seq_match_logger
    import seq_det_pkg::*;
#(
    parameter int unsigned IDX_W = IDX_W_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   det_in,
    input  logic                   clear_stats,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [IDX_W-1:0]       m_index,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic [CNT_W-1:0]       match_count,
    output logic [CNT_W-1:0]       drop_count,
    output logic                   overflow
);

    logic [IDX_W-1:0] idx_q;
    logic [CNT_W-1:0] match_count_q, match_count_d;
    logic [CNT_W-1:0] drop_count_q, drop_count_d;
    logic             overflow_q, overflow_d;
    logic             match;
    logic             pop;
    logic             drop;
    logic             full;
    logic             empty;

    assign match   = det_in & en;
    assign m_valid = ~empty;
    assign pop     = m_valid & m_ready;
    assign drop    = match & full & ~pop;

    // The FIFO itself refuses the push when full without a pop.
    sync_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(IDX_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (match),
        .pop   (pop),
        .wdata (idx_q),
        .rdata (m_index),
        .full  (full),
        .empty (empty),
        .level (fifo_level)
    );

    // Clear takes priority over a coincident match; the FIFO is unaffected by clear.
    always_comb begin
        match_count_d = match_count_q;
        drop_count_d  = drop_count_q;
        overflow_d    = overflow_q;
        if (clear_stats) begin
            match_count_d = '0;
            drop_count_d  = '0;
            overflow_d    = 1'b0;
        end else if (match) begin
            if (match_count_q != '1) match_count_d = match_count_q + CNT_W'(1);
            if (drop) begin
                if (drop_count_q != '1) drop_count_d = drop_count_q + CNT_W'(1);
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            idx_q         <= '0;
            match_count_q <= '0;
            drop_count_q  <= '0;
            overflow_q    <= 1'b0;
        end else begin
            if (en) idx_q <= idx_q + IDX_W'(1);
            match_count_q <= match_count_d;
            drop_count_q  <= drop_count_d;
            overflow_q    <= overflow_d;
        end
    end

    assign match_count = match_count_q;
    assign drop_count  = drop_count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_match_logger.sv
// Self-checking bench for seq_match_logger. Two instances share stimulus:
// "a" with default parameters and "b" with IDX_W=4, CNT_W=4, DEPTH=4 to reach
// index wrap and counter saturation quickly. A queue-based model tracks both.
module tb_seq_match_logger;

    logic clk = 1'b0;
    logic reset, en, det_in, clear_stats, m_ready;

    logic        a_valid, a_ovf;
    logic [15:0] a_index, a_mcnt, a_dcnt;
    logic [3:0]  a_level;
    logic        b_valid, b_ovf;
    logic [3:0]  b_index, b_mcnt, b_dcnt;
    logic [2:0]  b_level;

    always #5 clk = ~clk;

    seq_match_logger u_dut_a (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .det_in      (det_in),
        .clear_stats (clear_stats),
        .m_valid     (a_valid),
        .m_ready     (m_ready),
        .m_index     (a_index),
        .fifo_level  (a_level),
        .match_count (a_mcnt),
        .drop_count  (a_dcnt),
        .overflow    (a_ovf)
    );

    seq_match_logger #(
        .IDX_W(4),
        .CNT_W(4),
        .DEPTH(4)
    ) u_dut_b (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .det_in      (det_in),
        .clear_stats (clear_stats),
        .m_valid     (b_valid),
        .m_ready     (m_ready),
        .m_index     (b_index),
        .fifo_level  (b_level),
        .match_count (b_mcnt),
        .drop_count  (b_dcnt),
        .overflow    (b_ovf)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    int q0[$];
    int q1[$];
    int m_idx[2];
    int m_mcnt[2];
    int m_dcnt[2];
    int m_ovf[2];

    function automatic int p_iw(int k);  return (k == 0) ? 16 : 4; endfunction
    function automatic int p_cw(int k);  return (k == 0) ? 16 : 4; endfunction
    function automatic int p_dep(int k); return (k == 0) ? 8 : 4;  endfunction

    function automatic int q_size(int k);
        return (k == 0) ? q0.size() : q1.size();
    endfunction
    function automatic int q_head(int k);
        return (k == 0) ? q0[0] : q1[0];
    endfunction
    function automatic void q_pop(int k);
        if (k == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction
    function automatic void q_push(int k, int v);
        if (k == 0) q0.push_back(v);
        else        q1.push_back(v);
    endfunction

    function automatic void model_step(int k, bit r, bit e, bit d, bit c, bit rd);
        bit pop, match, full, dropped;
        int cmax;
        cmax = (1 << p_cw(k)) - 1;
        if (r) begin
            if (k == 0) q0.delete(); else q1.delete();
            m_idx[k] = 0; m_mcnt[k] = 0; m_dcnt[k] = 0; m_ovf[k] = 0;
            return;
        end
        pop     = (q_size(k) > 0) && rd;
        match   = e && d;
        full    = (q_size(k) == p_dep(k));
        dropped = match && full && !pop;
        if (pop) q_pop(k);
        if (match && !dropped) q_push(k, m_idx[k]);
        if (c) begin
            m_mcnt[k] = 0; m_dcnt[k] = 0; m_ovf[k] = 0;
        end else if (match) begin
            m_mcnt[k] = (m_mcnt[k] < cmax) ? m_mcnt[k] + 1 : cmax;
            if (dropped) begin
                m_dcnt[k] = (m_dcnt[k] < cmax) ? m_dcnt[k] + 1 : cmax;
                m_ovf[k]  = 1;
            end
        end
        if (e) m_idx[k] = (m_idx[k] + 1) % (1 << p_iw(k));
    endfunction

    task automatic compare(input int k);
        int v, ix, lv, mc, dc, of;
        if (k == 0) begin
            v = int'(a_valid); ix = int'(a_index); lv = int'(a_level);
            mc = int'(a_mcnt); dc = int'(a_dcnt); of = int'(a_ovf);
        end else begin
            v = int'(b_valid); ix = int'(b_index); lv = int'(b_level);
            mc = int'(b_mcnt); dc = int'(b_dcnt); of = int'(b_ovf);
        end
        check($sformatf("dut%0d m_valid", k), v, (q_size(k) > 0) ? 1 : 0);
        if (q_size(k) > 0) check($sformatf("dut%0d m_index", k), ix, q_head(k));
        check($sformatf("dut%0d fifo_level", k), lv, q_size(k));
        check($sformatf("dut%0d match_count", k), mc, m_mcnt[k]);
        check($sformatf("dut%0d drop_count", k), dc, m_dcnt[k]);
        check($sformatf("dut%0d overflow", k), of, m_ovf[k]);
    endtask

    // Apply inputs for one cycle, advance the model, then sample 1 time unit after the edge.
    task automatic tick(input bit r, input bit e, input bit d, input bit c, input bit rd);
        reset = r; en = e; det_in = d; clear_stats = c; m_ready = rd;
        for (int k = 0; k < 2; k++) model_step(k, r, e, d, c, rd);
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
    endtask

    typedef struct {
        bit en;
        bit det;
        bit rdy;
        bit exp_valid;
        int exp_index;
        int exp_count;
    } vec_t;

    vec_t t1[11];

    initial begin
        reset = 1'b1; en = 1'b0; det_in = 1'b0; clear_stats = 1'b0; m_ready = 1'b0;

        // Reset state, with other inputs active to show reset wins.
        tick(1, 1, 1, 1, 1);
        tick(1, 0, 0, 0, 0);
        check("reset m_valid", a_valid, 0);
        check("reset level", a_level, 0);
        check("reset match_count", a_mcnt, 0);
        check("reset overflow", a_ovf, 0);

        // Matches at idx 3, 7, 9 with consumer always ready.
        t1[0]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        t1[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        t1[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 0};
        t1[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 3, 1};
        t1[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
        t1[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
        t1[6]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 1};
        t1[7]  = '{1'b1, 1'b1, 1'b1, 1'b1, 7, 2};
        t1[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 2};
        t1[9]  = '{1'b1, 1'b1, 1'b1, 1'b1, 9, 3};
        t1[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 0, 3};
        for (int i = 0; i < 11; i++) begin
            tick(0, t1[i].en, t1[i].det, 0, t1[i].rdy);
            check($sformatf("t1[%0d] m_valid", i), a_valid, t1[i].exp_valid);
            if (t1[i].exp_valid) check($sformatf("t1[%0d] m_index", i), a_index, t1[i].exp_index);
            check($sformatf("t1[%0d] match_count", i), a_mcnt, t1[i].exp_count);
        end

        // Ten matches into an 8-deep FIFO with no consumer, then drain.
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 10; i++) tick(0, 1, 1, 0, 0);
        check("fill level", a_level, 8);
        check("fill drop_count", a_dcnt, 2);
        check("fill overflow", a_ovf, 1);
        check("fill match_count", a_mcnt, 10);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("drain[%0d] index", i), a_index, i);
            tick(0, 0, 0, 0, 1);
        end
        check("drained valid", a_valid, 0);

        // Full FIFO, match with simultaneous pop: no drop, new stamp at the tail.
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) tick(0, 1, 1, 0, 0);
        tick(0, 1, 1, 0, 1);
        check("pushpop level", a_level, 8);
        check("pushpop drop_count", a_dcnt, 0);
        for (int i = 1; i <= 8; i++) begin
            check($sformatf("pushpop drain[%0d]", i), a_index, i);
            tick(0, 0, 0, 0, 1);
        end

        // Index wrap on the 4-bit instance; en=0 matches are ignored.
        tick(1, 0, 0, 0, 0);
        for (int c = 0; c < 20; c++) begin
            if (c == 5 || c == 12) tick(0, 0, 1, 0, 0);
            tick(0, 1, (c == 17), 0, 0);
        end
        check("wrap b_index", b_index, 1);
        check("wrap b_match_count", b_mcnt, 1);
        check("wrap b_level", b_level, 1);
        check("wrap a_index", a_index, 17);

        // clear_stats coincident with a dropped match on a full FIFO.
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 9; i++) tick(0, 1, 1, 0, 0);
        check("pre-clear overflow", a_ovf, 1);
        check("pre-clear drop_count", a_dcnt, 1);
        tick(0, 1, 1, 1, 0);
        check("clear match_count", a_mcnt, 0);
        check("clear drop_count", a_dcnt, 0);
        check("clear overflow", a_ovf, 0);
        check("clear level", a_level, 8);
        check("clear m_index", a_index, 0);

        // Saturation on the 4-bit counters.
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) tick(0, 1, 1, 0, 0);
        check("sat b_match_count", b_mcnt, 15);
        check("sat b_drop_count", b_dcnt, 15);
        check("sat b_overflow", b_ovf, 1);
        check("sat a_match_count", a_mcnt, 20);
        check("sat a_drop_count", a_dcnt, 12);

        // Reset mid-stream with entries queued.
        tick(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) tick(0, 1, (i % 2 == 0), 0, 0);
        check("pre-reset level", a_level, 3);
        tick(1, 1, 1, 0, 1);
        check("midreset m_valid", a_valid, 0);
        check("midreset level", a_level, 0);
        check("midreset match_count", a_mcnt, 0);
        tick(0, 1, 1, 0, 0);
        check("post-reset m_index", a_index, 0);
        check("post-reset m_valid", a_valid, 1);

        // Randomised traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick(($urandom_range(199) == 0), ($urandom_range(3) != 0), $urandom_range(1) == 1,
                 ($urandom_range(49) == 0), ($urandom_range(2) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
